round_pipe: RTL and testbench
=============================

Name: round_pipe

Overview:
- Parametrised, pipelined rounding stage: drops NBITS LSBs of a DIN-bit word under a per-transaction rounding mode.
- Adds signed support, optional saturation and optional width trimming.
- Registered valid/ready stages; sits in datapath (DSP/fixed-point) chains between producer and consumer interfaces.

Parameters:
- DIN, 16, input word width (DIN > NBITS).
- NBITS, 4, number of LSBs rounded away (>= 1).
- SIGNED, 0, 1 = two's-complement input, 0 = unsigned.
- SAT, 1, 1 = saturate on round-up overflow, 0 = wrap.
- TRIM, 0, 1 = output DIN-NBITS bits (kept field only); 0 = output DIN bits with NBITS zero LSBs.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- din_valid  input  1  input word valid
- din_ready  output  1  input accepted when din_valid & din_ready
- din_data  input  DIN  word to round
- din_mode  input  2  rounding mode, sampled with din_data
- dout_valid  output  1  result valid
- dout_ready  input  1  consumer ready
- dout_data  output  DOUT  result; DOUT = TRIM ? DIN-NBITS : DIN

Behaviour:
- Reset (rst=0, async): both stage valids cleared. dout_valid=0, dout_data=0, din_ready=1 after release. Reset mid-transfer discards in-flight words; no partial output.
- Split din_data into K = din_data[DIN-1:NBITS] and F = din_data[NBITS-1:0]. H = 1<<(NBITS-1).
- Mode 0, TRUNC: K unchanged (floor).
- Mode 1, HALF_UP: K+1 if F >= H.
- Mode 2, HALF_EVEN: K+1 if F > H, or if F == H and K[0] == 1.
- Mode 3, HALF_AWAY: unsigned or K non-negative → as HALF_UP. Negative K (SIGNED=1, MSB=1) → K+1 only if F > H.
- Increment is computed on a (DIN-NBITS+1)-bit extension.
- Overflow: unsigned → carry out. Signed → K was max positive (0111..1) and increment applied.
- On overflow: SAT=1 yields max kept value (all ones unsigned, 011..1 signed). SAT=0 wraps. Negative overflow is impossible.
- Output: TRIM=1 gives the rounded K; TRIM=0 gives {rounded K, NBITS'b0}.
- Pipeline:
  - S1 registers din_data/din_mode on accept.
  - S2 registers the rounded result and drives dout_*.
  - Latency 2 cycles from accept to dout_valid. Throughput 1 word/cycle.
- Stage advance rule: a stage loads when it is empty or its contents are being taken downstream in the same cycle. s2 is taken when dout_valid & dout_ready.
- din_ready = !s1_valid | s1_advance (combinational from dout_ready).
- Stalled output: dout_data/dout_valid hold stable while dout_valid & !dout_ready.
- Simultaneous accept and emit in one cycle is legal; no bubble.
- Full pipeline with dout_ready=0: din_ready=0, exactly two words held.
- Mode is captured per word; changing din_mode while stalled (din_valid & !din_ready) has no effect until accepted.

Optional Feature:
- Macro ROUND_PIPE_OVF_STAT_EN.
- Defined:
  - Extra outputs ovf_sticky (1) and ovf_count (16).
  - On each S2 emit whose word overflowed (saturated or wrapped): sticky set, count increments, saturating at 0xFFFF.
  - Input clr_stat (1) clears both synchronously; clr_stat wins over a same-cycle increment.
  - Both reset to 0.
- Undefined: ports and logic absent; data behaviour identical.

Decomposition:
- Package round_pkg:
  - Mode encodings: RND_TRUNC=0, RND_HALF_UP=1, RND_HALF_EVEN=2, RND_HALF_AWAY=3.
  - Function computing the round-up decision from K[0], F, sign and mode.
- One sub-module round_pipe_stage: generic WIDTH-parametrised valid/ready register stage, instantiated twice.

Test Plan:
- DIN=16, NBITS=4, unsigned, TRIM=0, HALF_EVEN: 0x0018→0x0020, 0x0028→0x0020, 0x0027→0x0020, 0x0029→0x0030.
- Unsigned, HALF_UP, 0xFFF8: SAT=1 → 0xFFF0; SAT=0 → 0x0000. With ROUND_PIPE_OVF_STAT_EN, ovf_count=1, ovf_sticky=1.
- SIGNED=1, input 0xFFE8 (-1.5): TRUNC→0xFFE0, HALF_UP→0xFFF0, HALF_EVEN→0xFFE0, HALF_AWAY→0xFFE0. Input 0x7FF8 HALF_UP with SAT=1 → 0x7FF0.
- TRIM=1, unsigned, HALF_UP, 0x1238 → 0x124 (12-bit output).
- Backpressure:
  - Stream 0x0010..0x0100 step 0x10 continuously with random dout_ready.
  - Outputs arrive in order, none lost or duplicated.
  - din_ready=0 exactly when two words are held.
  - First output 2 cycles after first accept when dout_ready=1.
- Reset: drive rst=0 asynchronously while two words are held → dout_valid drops immediately, no stale output after release.

Source files
------------

// File: rtl/round_pkg.sv
// Shared definitions for round_pipe: rounding mode encodings and round-up decision.
package round_pkg;

   typedef enum logic [1:0] {
      RND_TRUNC     = 2'd0,
      RND_HALF_UP   = 2'd1,
      RND_HALF_EVEN = 2'd2,
      RND_HALF_AWAY = 2'd3
   } round_mode_e;

   // f_gt_h / f_eq_h compare the dropped fraction against one half; neg marks a negative kept field.
   function automatic logic round_up(input logic        k_lsb,
                                     input logic        f_gt_h,
                                     input logic        f_eq_h,
                                     input logic        neg,
                                     input round_mode_e mode);
      logic up;
      up = 1'b0;
      case (mode)
         RND_TRUNC:     up = 1'b0;
         RND_HALF_UP:   up = f_gt_h | f_eq_h;
         RND_HALF_EVEN: up = f_gt_h | (f_eq_h & k_lsb);
         RND_HALF_AWAY: up = neg ? f_gt_h : (f_gt_h | f_eq_h);
         default:       up = 1'b0;
      endcase
      return up;
   endfunction

endpackage

// File: rtl/round_pipe_stage.sv
// Generic valid/ready register stage: loads when empty or when its word is taken downstream.
module round_pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end

endmodule

// File: rtl/round_pipe.sv
// Two-stage pipelined rounder dropping NBITS LSBs under a per-word mode.
// Optional overflow statistics (ovf_sticky, ovf_count, clr_stat) under `ROUND_PIPE_OVF_STAT_EN.
module round_pipe
   import round_pkg::*;
#(
   parameter int DIN    = 16,
   parameter int NBITS  = 4,
   parameter int SIGNED = 0,
   parameter int SAT    = 1,
   parameter int TRIM   = 0
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    din_valid,
   output logic                                    din_ready,
   input  logic [DIN-1:0]                          din_data,
   input  logic [1:0]                              din_mode,
   output logic                                    dout_valid,
   input  logic                                    dout_ready,
`ifdef ROUND_PIPE_OVF_STAT_EN
   input  logic                                    clr_stat,
   output logic                                    ovf_sticky,
   output logic [15:0]                             ovf_count,
`endif
   output logic [((TRIM != 0) ? DIN-NBITS : DIN)-1:0] dout_data
);

   localparam int KW   = DIN - NBITS;
   localparam int DOUT = (TRIM != 0) ? KW : DIN;
   localparam logic [NBITS-1:0] H     = NBITS'(1) << (NBITS - 1);
   localparam logic [KW-1:0]    K_MAX = (SIGNED != 0) ? ({KW{1'b1}} >> 1) : {KW{1'b1}};
`ifdef ROUND_PIPE_OVF_STAT_EN
   localparam int S2W = DOUT + 1;
`else
   localparam int S2W = DOUT;
`endif

   logic             s1_valid, s2_in_ready;
   logic [DIN+1:0]   s1_data;
   logic [DIN-1:0]   s1_word;
   logic [1:0]       s1_mode;
   logic [KW-1:0]    k, k_sel;
   logic [NBITS-1:0] f;
   logic [KW:0]      inc;
   logic             up, neg, ovf;
   logic [DOUT-1:0]  r_out;
   logic [S2W-1:0]   s2_in, s2_data;

   round_pipe_stage #(.WIDTH(DIN + 2)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (din_valid),
      .in_ready  (din_ready),
      .in_data   ({din_mode, din_data}),
      .out_valid (s1_valid),
      .out_ready (s2_in_ready),
      .out_data  (s1_data)
   );

   assign s1_word = s1_data[DIN-1:0];
   assign s1_mode = s1_data[DIN+1:DIN];

   always_comb begin
      k     = s1_word[DIN-1:NBITS];
      f     = s1_word[NBITS-1:0];
      neg   = (SIGNED != 0) && k[KW-1];
      up    = round_up(k[0], f > H, f == H, neg, round_mode_e'(s1_mode));
      inc   = {1'b0, k} + (KW + 1)'(up);
      // Signed overflow only occurs when max positive is pushed into the sign bit.
      ovf   = (SIGNED != 0) ? ((k == K_MAX) && up) : inc[KW];
      k_sel = (ovf && (SAT != 0)) ? K_MAX : inc[KW-1:0];
   end

   generate
      if (TRIM != 0) begin : g_trim
         assign r_out = k_sel;
      end else begin : g_full
         assign r_out = {k_sel, {NBITS{1'b0}}};
      end
   endgenerate

`ifdef ROUND_PIPE_OVF_STAT_EN
   assign s2_in     = {ovf, r_out};
   assign dout_data = s2_data[DOUT-1:0];
`else
   assign s2_in     = r_out;
   assign dout_data = s2_data;
`endif

   round_pipe_stage #(.WIDTH(S2W)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid),
      .in_ready  (s2_in_ready),
      .in_data   (s2_in),
      .out_valid (dout_valid),
      .out_ready (dout_ready),
      .out_data  (s2_data)
   );

`ifdef ROUND_PIPE_OVF_STAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else if (clr_stat) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else if (dout_valid && dout_ready && s2_data[DOUT]) begin
         ovf_sticky <= 1'b1;
         if (ovf_count != '1) ovf_count <= ovf_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_round_pipe.sv
// Directed self-checking bench for round_pipe: unsigned/wrap/signed/trim variants, backpressure, reset.
module tb_round_pipe;
   import round_pkg::*;

   logic        clk, rst, rdy;
   logic [15:0] din_data;
   logic [1:0]  din_mode;
   logic        vin [4];
   logic        dr  [4];
   logic        dv  [4];
   logic [15:0] dd  [4];
   logic [11:0] td;
`ifdef ROUND_PIPE_OVF_STAT_EN
   logic        clr;
   logic        os [4];
   logic [15:0] oc [4];
`endif

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0: unsigned SAT, 1: unsigned wrap, 2: signed SAT
   for (genvar g = 0; g < 3; g++) begin : g_dut
      round_pipe #(.DIN(16), .NBITS(4), .SIGNED((g == 2) ? 1 : 0), .SAT((g == 1) ? 0 : 1), .TRIM(0)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .din_valid  (vin[g]),
         .din_ready  (dr[g]),
         .din_data   (din_data),
         .din_mode   (din_mode),
         .dout_valid (dv[g]),
         .dout_ready (rdy),
`ifdef ROUND_PIPE_OVF_STAT_EN
         .clr_stat   (clr),
         .ovf_sticky (os[g]),
         .ovf_count  (oc[g]),
`endif
         .dout_data  (dd[g])
      );
   end

   round_pipe #(.DIN(16), .NBITS(4), .SIGNED(0), .SAT(1), .TRIM(1)) u_trim (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (vin[3]),
      .din_ready  (dr[3]),
      .din_data   (din_data),
      .din_mode   (din_mode),
      .dout_valid (dv[3]),
      .dout_ready (rdy),
`ifdef ROUND_PIPE_OVF_STAT_EN
      .clr_stat   (clr),
      .ovf_sticky (os[3]),
      .ovf_count  (oc[3]),
`endif
      .dout_data  (td)
   );
   assign dd[3] = {4'h0, td};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic one(input int sel, input logic [15:0] d, input logic [1:0] m,
                      input logic [15:0] exp, input string tag);
      @(negedge clk);
      vin[sel] = 1'b1; din_data = d; din_mode = m;
      @(posedge clk); #1;
      chk({tag, "_lat"}, 32'(dv[sel]), 32'd0);
      @(negedge clk);
      vin[sel] = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_v"}, 32'(dv[sel]), 32'd1);
      chk(tag, 32'(dd[sel]), 32'(exp));
   endtask

   initial begin
      int sent, rcvd, occ, cyc;
      logic in_hs, out_hs, stall_prev;
      logic [15:0] stall_data;

      rst = 1'b0; rdy = 1'b1; din_data = '0; din_mode = '0;
      for (int i = 0; i < 4; i++) vin[i] = 1'b0;
`ifdef ROUND_PIPE_OVF_STAT_EN
      clr = 1'b0;
`endif
      #1;
      chk("rst_dout_valid", 32'(dv[0]), 32'd0);
      chk("rst_dout_data", 32'(dd[0]), 32'd0);
      #11 rst = 1'b1;
      #1 chk("rst_din_ready", 32'(dr[0]), 32'd1);

      one(0, 16'h0018, RND_HALF_EVEN, 16'h0020, "he_0018");
      one(0, 16'h0028, RND_HALF_EVEN, 16'h0020, "he_0028");
      one(0, 16'h0027, RND_HALF_EVEN, 16'h0020, "he_0027");
      one(0, 16'h0029, RND_HALF_EVEN, 16'h0030, "he_0029");
      one(0, 16'h0027, RND_TRUNC,     16'h0020, "tr_0027");
      one(0, 16'h0018, RND_HALF_UP,   16'h0020, "hu_0018");
      one(0, 16'hFFF8, RND_HALF_UP,   16'hFFF0, "sat_fff8");
`ifdef ROUND_PIPE_OVF_STAT_EN
      @(posedge clk); #1;
      chk("ovf_count", 32'(oc[0]), 32'd1);
      chk("ovf_sticky", 32'(os[0]), 32'd1);
      @(negedge clk); clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      chk("ovf_clr_count", 32'(oc[0]), 32'd0);
      chk("ovf_clr_sticky", 32'(os[0]), 32'd0);
`endif
      one(1, 16'hFFF8, RND_HALF_UP,   16'h0000, "wrap_fff8");
      one(2, 16'hFFE8, RND_TRUNC,     16'hFFE0, "s_tr_ffe8");
      one(2, 16'hFFE8, RND_HALF_UP,   16'hFFF0, "s_hu_ffe8");
      one(2, 16'hFFE8, RND_HALF_EVEN, 16'hFFE0, "s_he_ffe8");
      one(2, 16'hFFE8, RND_HALF_AWAY, 16'hFFE0, "s_ha_ffe8");
      one(2, 16'h0018, RND_HALF_AWAY, 16'h0020, "s_ha_0018");
      one(2, 16'h7FF8, RND_HALF_UP,   16'h7FF0, "s_sat_7ff8");
      one(3, 16'h1238, RND_HALF_UP,   16'h0124, "trim_1238");

      // streaming with random backpressure
      sent = 0; rcvd = 0; occ = 0; cyc = 0; stall_prev = 1'b0; stall_data = '0;
      @(posedge clk);
      while (rcvd < 16 && cyc < 500) begin
         @(negedge clk);
         vin[0] = (sent < 16);
         din_data = 16'(16'h10 * (sent + 1));
         din_mode = RND_TRUNC;
         rdy = 1'($urandom_range(0, 1));
         #1;
         if (stall_prev) begin
            chk("stall_hold_v", 32'(dv[0]), 32'd1);
            chk("stall_hold_d", 32'(dd[0]), 32'(stall_data));
         end
         chk("bp_din_ready", 32'(dr[0]), 32'(!(occ == 2 && !rdy)));
         in_hs  = vin[0] && dr[0];
         out_hs = dv[0] && rdy;
         if (out_hs) begin
            chk("stream_data", 32'(dd[0]), 32'(16'h10 * (rcvd + 1)));
            rcvd++;
         end
         stall_prev = dv[0] && !rdy;
         stall_data = dd[0];
         if (in_hs) sent++;
         occ = occ + int'(in_hs) - int'(out_hs);
         cyc++;
      end
      chk("stream_count", 32'(rcvd), 32'd16);
      vin[0] = 1'b0;

      // fill both stages, then reset asynchronously
      @(negedge clk);
      rdy = 1'b0; vin[0] = 1'b1; din_data = 16'h0050; din_mode = RND_TRUNC;
      @(negedge clk);
      din_data = 16'h0060;
      @(negedge clk);
      vin[0] = 1'b0;
      #1;
      chk("full_dout_valid", 32'(dv[0]), 32'd1);
      chk("full_din_ready", 32'(dr[0]), 32'd0);
      #1 rst = 1'b0;
      #1;
      chk("arst_dout_valid", 32'(dv[0]), 32'd0);
      chk("arst_dout_data", 32'(dd[0]), 32'd0);
      #1 rst = 1'b1;
      rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_valid", 32'(dv[0]), 32'd0);
      chk("post_rst_ready", 32'(dr[0]), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
